store_buffer: RTL and testbench

Write buffer between the core's load/store datapath and `data_memory`. Queues up to `DEPTH` stores and drains them in order, one per cycle, whenever the shared memory port is free. Loads go straight through to `data_memory`. A load that overlaps any queued store stalls the core until that store has drained, so loads never read stale bytes. A flush input and an empty output provide fence semantics.

---
 rtl/controls.sv | 23 ++
 rtl/sb_fifo.sv | 69 ++++++
 rtl/store_buffer.sv | 103 ++++++++++
 tb/tb_store_buffer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controls.sv
// Shared load/store encodings and the store-buffer entry layout.
package controls;

  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  localparam logic [1:0] LS_BYTE = 2'd0;
  localparam logic [1:0] LS_HALF = 2'd1;
  localparam logic [1:0] LS_WORD = 2'd2;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
    logic [1:0]           ls_type;
  } sb_entry_t;

  // Exclusive upper byte bound, one bit wider so a range never wraps past zero.
  function automatic logic [SB_ADDR_W:0] range_hi(input logic [SB_ADDR_W-1:0] addr,
                                                  input logic [1:0] ls_type);
    return {1'b0, addr} + ((SB_ADDR_W+1)'(1) << ls_type);
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular store queue; every slot and its valid bit are exposed for overlap checks.
module sb_fifo
  import controls::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  sb_entry_t                 push_entry,
  input  logic                      pop,
  output sb_entry_t                 head,
  output sb_entry_t [DEPTH-1:0]     entries,
  output logic [DEPTH-1:0]          valid,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t [DEPTH-1:0] slot_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [PW-1:0]         wr_ptr_r;
  logic [CW-1:0]         count_r;
  logic [PW-1:0]         offset_s;

  // Slot storage needs no reset: stale slots are masked by valid.
  always_ff @(posedge clk) begin
    if (push) begin
      slot_r[wr_ptr_r] <= push_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // A slot is live when its distance from the head is below the fill level.
  always_comb begin
    valid    = {DEPTH{1'b0}};
    offset_s = {PW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      offset_s = PW'(i) - rd_ptr_r;
      valid[i] = ({1'b0, offset_s} < count_r);
    end
  end

  assign head    = slot_r[rd_ptr_r];
  assign entries = slot_r;
  assign count   = count_r;

endmodule

// File: rtl/store_buffer.sv
// Write buffer in front of data_memory: queues stores, drains in order, stalls overlapping loads.
module store_buffer
  import controls::*;
#(
  parameter int ADDR_WIDTH = SB_ADDR_W,
  parameter int DATA_WIDTH = SB_DATA_W,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_write_data,
  input  logic [1:0]            req_type,
  input  logic                  req_unsigned,
  input  logic                  flush,
  output logic                  stall,
  output logic                  empty,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [1:0]            mem_type,
  output logic                  mem_unsigned
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  sb_entry_t             head_s;
  sb_entry_t [DEPTH-1:0] entries_s;
  logic [DEPTH-1:0]      valid_s;
  logic [CW-1:0]         count_s;
  logic                  hazard_s;
  logic                  load_go_s;
  logic                  drain_s;
  logic                  accept_s;
  logic                  push_s;
  logic [ADDR_WIDTH:0]   a_lo_s;
  logic [ADDR_WIDTH:0]   a_hi_s;

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_entry ('{addr: req_address, data: req_write_data, ls_type: req_type}),
    .pop        (drain_s),
    .head       (head_s),
    .entries    (entries_s),
    .valid      (valid_s),
    .count      (count_s)
  );

  // Load hazard: the request's byte range intersects any live entry's range.
  always_comb begin
    hazard_s = 1'b0;
    a_lo_s   = {1'b0, req_address};
    a_hi_s   = range_hi(req_address, req_type);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_s[i] && (a_lo_s < range_hi(entries_s[i].addr, entries_s[i].ls_type))
          && ({1'b0, entries_s[i].addr} < a_hi_s)) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  // Reset suppresses drain and push so queued stores are dropped, never written.
  assign load_go_s = req_valid && !req_write && !hazard_s;
  assign drain_s   = !rst && !load_go_s && (count_s != {CW{1'b0}}) && mem_ready;
  assign accept_s  = ((count_s < DEPTH_C) || drain_s) && !flush;
  assign push_s    = !rst && req_valid && req_write && accept_s;
  assign empty     = (count_s == {CW{1'b0}});
  assign stall     = (req_valid && ((req_write && !accept_s) || (!req_write && hazard_s)))
                     || (flush && !empty);

  // Memory port arbitration: clean load first, then head drain, else idle.
  always_comb begin
    mem_address    = {ADDR_WIDTH{1'b0}};
    mem_write_data = {DATA_WIDTH{1'b0}};
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_type       = 2'd0;
    mem_unsigned   = 1'b0;
    if (load_go_s) begin
      mem_read     = 1'b1;
      mem_address  = req_address;
      mem_type     = req_type;
      mem_unsigned = req_unsigned;
    end else if (drain_s) begin
      mem_write      = 1'b1;
      mem_address    = head_s.addr;
      mem_write_data = head_s.data;
      mem_type       = head_s.ls_type;
    end else begin
      mem_read = 1'b0;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a byte-array memory model and a write scoreboard.
module tb_store_buffer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_address;
  logic [31:0] req_write_data;
  logic [1:0]  req_type;
  logic        req_unsigned;
  logic        flush;
  logic        stall;
  logic        empty;
  logic        mem_ready;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_type;
  logic        mem_unsigned;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  t;
  } exp_t;

  exp_t     exp_q[$];
  bit [7:0] mem[256];
  int       checks = 0;
  int       errors = 0;

  store_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_address(req_address), .req_write_data(req_write_data), .req_type(req_type),
    .req_unsigned(req_unsigned), .flush(flush), .stall(stall), .empty(empty),
    .mem_ready(mem_ready), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_type(mem_type),
    .mem_unsigned(mem_unsigned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // data_memory model: byte-addressed, written on the rising edge
  always @(posedge clk) begin
    if (mem_write === 1'b1) begin
      case (mem_type)
        2'd0: mem[mem_address[7:0]] <= mem_write_data[7:0];
        2'd1: begin
          mem[mem_address[7:0]]         <= mem_write_data[7:0];
          mem[mem_address[7:0] + 8'd1]  <= mem_write_data[15:8];
        end
        default: begin
          mem[mem_address[7:0]]         <= mem_write_data[7:0];
          mem[mem_address[7:0] + 8'd1]  <= mem_write_data[15:8];
          mem[mem_address[7:0] + 8'd2]  <= mem_write_data[23:16];
          mem[mem_address[7:0] + 8'd3]  <= mem_write_data[31:24];
        end
      endcase
    end
  end

  // Every drained write must match the oldest outstanding accepted store
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL wr_unexpected observed=%h expected=none", mem_address);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", mem_address, e.a);
        chk("wr_data", mem_write_data, e.d);
        chk("wr_type", {30'd0, mem_type}, {30'd0, e.t});
      end
    end
  end

  function automatic logic [31:0] mword(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  function automatic logic [31:0] load_val(input logic [7:0] a, input logic [1:0] t, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    b = mem[a];
    h = {mem[a + 8'd1], mem[a]};
    case (t)
      2'd0:    return u ? {24'd0, b} : {{24{b[7]}}, b};
      2'd1:    return u ? {16'd0, h} : {{16{h[15]}}, h};
      default: return mword(int'(a));
    endcase
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid      = 1'b0;
    req_write      = 1'b0;
    req_address    = 32'd0;
    req_write_data = 32'd0;
    req_type       = 2'd0;
    req_unsigned   = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
    req_valid = 1'b1; req_write = 1'b1; req_address = a;
    req_write_data = d; req_type = t; req_unsigned = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] t, input logic u);
    req_valid = 1'b1; req_write = 1'b0; req_address = a;
    req_write_data = 32'd0; req_type = t; req_unsigned = u;
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
    exp_t e;
    e.a = a; e.d = d; e.t = t;
    exp_q.push_back(e);
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (empty === 1'b1) break;
      nxt();
    end
    chk(tag, {31'd0, empty}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    idle();
    flush = 1'b0; mem_ready = 1'b1; rst = 1'b1;
    nxt(); nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_addr", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    nxt();

    // SW then three idle cycles: drains one cycle after acceptance
    store(32'h10, 32'hDEADBEEF, 2'd2);
    expect_wr(32'h10, 32'hDEADBEEF, 2'd2);
    @(negedge clk);
    chk("sw_stall", {31'd0, stall}, 32'd0);
    chk("sw_no_bypass", {31'd0, mem_write}, 32'd0);
    nxt();
    idle();
    @(negedge clk);
    chk("sw_drain", {31'd0, mem_write}, 32'd1);
    nxt(); nxt();
    @(negedge clk);
    chk("sw_mem", mword(32'h10), 32'hDEADBEEF);
    chk("sw_empty", {31'd0, empty}, 32'd1);
    nxt();

    // Fill with memory busy; fifth store stalls until the first drain frees a slot
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      store(32'h30 + 32'(i), 32'hA0 + 32'(i), 2'd0);
      expect_wr(32'h30 + 32'(i), 32'hA0 + 32'(i), 2'd0);
      @(negedge clk);
      chk("fill_stall", {31'd0, stall}, 32'd0);
      nxt();
    end
    store(32'h34, 32'hA4, 2'd0);
    @(negedge clk);
    chk("full_stall", {31'd0, stall}, 32'd1);
    chk("full_no_write", {31'd0, mem_write}, 32'd0);
    nxt();
    mem_ready = 1'b1;
    expect_wr(32'h34, 32'hA4, 2'd0);
    @(negedge clk);
    chk("full_accept", {31'd0, stall}, 32'd0);
    chk("full_drain", {31'd0, mem_write}, 32'd1);
    nxt();
    idle();
    wait_empty("fill_empty");
    for (int i = 0; i < 5; i++) begin
      chk("fill_byte", {24'd0, mem[8'h30 + 8'(i)]}, 32'hA0 + 32'(i));
    end

    // Overlapping LBU stalls one cycle, then reads the freshly drained byte
    store(32'h20, 32'h11223344, 2'd2);
    expect_wr(32'h20, 32'h11223344, 2'd2);
    nxt();
    load(32'h22, 2'd0, 1'b1);
    @(negedge clk);
    chk("haz_stall", {31'd0, stall}, 32'd1);
    chk("haz_no_read", {31'd0, mem_read}, 32'd0);
    nxt();
    @(negedge clk);
    chk("haz_release", {31'd0, stall}, 32'd0);
    chk("haz_read", {31'd0, mem_read}, 32'd1);
    chk("haz_addr", mem_address, 32'h22);
    chk("haz_data", load_val(mem_address[7:0], mem_type, mem_unsigned), 32'h22);
    nxt();

    // Non-overlapping LW takes the port and defers the SH drain by a cycle
    store(32'h40, 32'h0000BEEF, 2'd1);
    expect_wr(32'h40, 32'h0000BEEF, 2'd1);
    nxt();
    load(32'h44, 2'd2, 1'b0);
    @(negedge clk);
    chk("lw_stall", {31'd0, stall}, 32'd0);
    chk("lw_read", {31'd0, mem_read}, 32'd1);
    chk("lw_no_write", {31'd0, mem_write}, 32'd0);
    chk("lw_addr", mem_address, 32'h44);
    nxt();
    idle();
    @(negedge clk);
    chk("lw_deferred", {31'd0, mem_write}, 32'd1);
    nxt();
    wait_empty("lw_empty");

    // Reset mid-drain discards the remaining stores
    mem_ready = 1'b0;
    store(32'h50, 32'h50505050, 2'd2); expect_wr(32'h50, 32'h50505050, 2'd2); nxt();
    store(32'h54, 32'h54545454, 2'd2); nxt();
    store(32'h58, 32'h58585858, 2'd2); nxt();
    idle();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("mid_drain", {31'd0, mem_write}, 32'd1);
    nxt();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_drop_write", {31'd0, mem_write}, 32'd0);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_empty", {31'd0, empty}, 32'd1);
    chk("rst_mid_write", {31'd0, mem_write}, 32'd0);
    nxt(); nxt();
    chk("rst_kept_50", mword(32'h50), 32'h50505050);
    chk("rst_lost_54", mword(32'h54), 32'd0);
    chk("rst_lost_58", mword(32'h58), 32'd0);

    // Flush with two queued stores holds a new SB until the queue empties
    mem_ready = 1'b0;
    store(32'h60, 32'h60606060, 2'd2); expect_wr(32'h60, 32'h60606060, 2'd2); nxt();
    store(32'h64, 32'h64646464, 2'd2); expect_wr(32'h64, 32'h64646464, 2'd2); nxt();
    mem_ready = 1'b1;
    flush = 1'b1;
    store(32'h68, 32'h77, 2'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("flush_stall", {31'd0, stall}, 32'd1);
      chk("flush_drain", {31'd0, mem_write}, 32'd1);
      nxt();
    end
    @(negedge clk);
    chk("flush_empty", {31'd0, empty}, 32'd1);
    chk("flush_sb_held", {31'd0, mem_write}, 32'd0);
    nxt();
    flush = 1'b0;
    expect_wr(32'h68, 32'h77, 2'd0);
    @(negedge clk);
    chk("post_flush_accept", {31'd0, stall}, 32'd0);
    nxt();
    idle();
    wait_empty("post_flush_empty");
    chk("post_flush_byte", {24'd0, mem[8'h68]}, 32'h77);
    chk("sb_leftover", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
